// File: rtl/snitch_icache_tag_ctrl.sv
// Instruction-cache tag controller.
// Drives the single-port tag SRAM for refill writes and lookups, compares the
// returned tags for hit/way/error, and runs the invalidation sweep after reset
// and on flush.
// Ports:
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   flush_i / busy_o               invalidate-all request / sweep in progress
//   lookup_req_i/gnt_o/addr_i/tag_i      lookup request channel
//   lookup_valid_o/ready_i/hit_o/way_o/error_o  lookup response channel
//   write_req_i/gnt_o/addr_i/way_i/tag_i/error_i refill tag write channel
//   sram_req_o/write_o/addr_o/wdata_o/be_o/rdata_i tag SRAM port (1-cycle read)

package snitch_icache_pkg;
  typedef struct packed {
    int unsigned LINE_COUNT;
    int unsigned WAY_COUNT;
    int unsigned TAG_WIDTH;
    int unsigned COUNT_ALIGN;
  } config_t;
endpackage

module snitch_icache_tag_ctrl #(
  parameter snitch_icache_pkg::config_t CFG = '0,
  localparam int unsigned WAYS  = (CFG.WAY_COUNT > 0) ? CFG.WAY_COUNT : 1,
  localparam int unsigned TW    = (CFG.TAG_WIDTH > 0) ? CFG.TAG_WIDTH : 1,
  localparam int unsigned LINES = (CFG.LINE_COUNT > 0) ? CFG.LINE_COUNT : 1,
  localparam int unsigned CA    = (CFG.COUNT_ALIGN > 0) ? CFG.COUNT_ALIGN : 1,
  localparam int unsigned WAYW  = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int unsigned EW    = TW + 2,
  localparam int unsigned DW    = WAYS * EW
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  output logic            busy_o,
  input  logic            lookup_req_i,
  output logic            lookup_gnt_o,
  input  logic [CA-1:0]   lookup_addr_i,
  input  logic [TW-1:0]   lookup_tag_i,
  output logic            lookup_valid_o,
  input  logic            lookup_ready_i,
  output logic            lookup_hit_o,
  output logic [WAYS-1:0] lookup_way_o,
  output logic            lookup_error_o,
  input  logic            write_req_i,
  output logic            write_gnt_o,
  input  logic [CA-1:0]   write_addr_i,
  input  logic [WAYW-1:0] write_way_i,
  input  logic [TW-1:0]   write_tag_i,
  input  logic            write_error_i,
  output logic            sram_req_o,
  output logic            sram_write_o,
  output logic [CA-1:0]   sram_addr_o,
  output logic [DW-1:0]   sram_wdata_o,
  output logic [WAYS-1:0] sram_be_o,
  input  logic [DW-1:0]   sram_rdata_i
);

  localparam logic [CA-1:0] LAST_LINE = CA'(LINES - 1);

  typedef enum logic {INIT, IDLE} state_e;

  state_e          state_q, state_d;
  logic [CA-1:0]   cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_held_q;
  logic [TW-1:0]   tag_q;
  logic            hit_q, error_q;
  logic [WAYS-1:0] way_q;

  logic            flush_start, lookup_fire;
  logic            cmp_hit, cmp_error;
  logic [WAYS-1:0] cmp_way;
  logic [EW-1:0]   entry;

  // Tag compare on the read data; ascending scan keeps the lowest matching way.
  always_comb begin
    cmp_hit   = 1'b0;
    cmp_way   = '0;
    cmp_error = 1'b0;
    entry     = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      entry = sram_rdata_i[w*EW +: EW];
      if (!cmp_hit && entry[EW-1] && (entry[TW-1:0] == tag_q)) begin
        cmp_hit    = 1'b1;
        cmp_way[w] = 1'b1;
        cmp_error  = entry[TW];
      end
    end
  end

  // Next state, grants and SRAM command.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_o       = 1'b1;
    write_gnt_o  = 1'b0;
    lookup_gnt_o = 1'b0;
    sram_req_o   = 1'b0;
    sram_write_o = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    flush_start  = 1'b0;
    lookup_fire  = 1'b0;
    if (rst_ni) begin
      unique case (state_q)
        INIT: begin
          sram_req_o   = 1'b1;
          sram_write_o = 1'b1;
          sram_addr_o  = cnt_q;
          sram_be_o    = '1;
          if (cnt_q == LAST_LINE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CA'(1);
          end
        end
        IDLE: begin
          busy_o = 1'b0;
          // A flush may only start once no response is left outstanding.
          flush_start  = flush_i && (!rsp_valid_q || lookup_ready_i);
          write_gnt_o  = !flush_start;
          lookup_gnt_o = !write_req_i && !flush_start && (!rsp_valid_q || lookup_ready_i);
          if (flush_start) begin
            state_d = INIT;
            cnt_d   = '0;
          end else if (write_req_i) begin
            sram_req_o   = 1'b1;
            sram_write_o = 1'b1;
            sram_addr_o  = write_addr_i;
            sram_wdata_o = {WAYS{{1'b1, write_error_i, write_tag_i}}};
            sram_be_o    = WAYS'(1) << write_way_i;
          end else if (lookup_req_i && lookup_gnt_o) begin
            lookup_fire = 1'b1;
            sram_req_o  = 1'b1;
            sram_addr_o = lookup_addr_i;
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  // State, sweep counter and response tracking.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_held_q  <= 1'b0;
      tag_q       <= '0;
      hit_q       <= 1'b0;
      way_q       <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= lookup_fire || (rsp_valid_q && !lookup_ready_i);
      rsp_held_q  <= rsp_valid_q && !lookup_ready_i;
      if (lookup_fire) tag_q <= lookup_tag_i;
      // Read data is only valid for one cycle, so a stalled result is frozen here.
      if (rsp_valid_q && !lookup_ready_i && !rsp_held_q) begin
        hit_q   <= cmp_hit;
        way_q   <= cmp_way;
        error_q <= cmp_error;
      end
    end
  end

  assign lookup_valid_o = rst_ni && rsp_valid_q;
  assign lookup_hit_o   = rsp_held_q ? hit_q   : cmp_hit;
  assign lookup_way_o   = rsp_held_q ? way_q   : cmp_way;
  assign lookup_error_o = rsp_held_q ? error_q : cmp_error;

endmodule

// File: tb/tb_snitch_icache_tag_ctrl.sv
// Testbench for snitch_icache_tag_ctrl (4 ways, 8-bit tags, 16 lines).
// A tag SRAM model backs the DUT; expected lookup results come from a
// per-line/per-way tag table maintained by the bench.

module tb_snitch_icache_tag_ctrl;

  localparam int unsigned LINES = 16;
  localparam int unsigned WAYS  = 4;
  localparam int unsigned EW    = 10;
  localparam int unsigned DW    = 40;
  localparam snitch_icache_pkg::config_t CFG =
    '{LINE_COUNT: 16, WAY_COUNT: 4, TAG_WIDTH: 8, COUNT_ALIGN: 4};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          busy;
  logic          lookup_req = 1'b0;
  logic          lookup_gnt;
  logic [3:0]    lookup_addr = '0;
  logic [7:0]    lookup_tag = '0;
  logic          lookup_valid;
  logic          ready = 1'b0;
  logic          hit;
  logic [3:0]    way;
  logic          err;
  logic          write_req = 1'b0;
  logic          write_gnt;
  logic [3:0]    write_addr = '0;
  logic [1:0]    write_way = '0;
  logic [7:0]    write_tag = '0;
  logic          write_error = 1'b0;
  logic          sram_req, sram_write;
  logic [3:0]    sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [3:0]    sram_be;
  logic [DW-1:0] sram_rdata;

  int passed = 0;
  int total  = 0;

  logic       mv [LINES][WAYS];
  logic       me [LINES][WAYS];
  logic [7:0] mt [LINES][WAYS];
  logic [DW-1:0] mem [LINES];

  always #5 clk = ~clk;

  snitch_icache_tag_ctrl #(.CFG(CFG)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .busy_o(busy),
    .lookup_req_i(lookup_req), .lookup_gnt_o(lookup_gnt),
    .lookup_addr_i(lookup_addr), .lookup_tag_i(lookup_tag),
    .lookup_valid_o(lookup_valid), .lookup_ready_i(ready),
    .lookup_hit_o(hit), .lookup_way_o(way), .lookup_error_o(err),
    .write_req_i(write_req), .write_gnt_o(write_gnt),
    .write_addr_i(write_addr), .write_way_i(write_way),
    .write_tag_i(write_tag), .write_error_i(write_error),
    .sram_req_o(sram_req), .sram_write_o(sram_write), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  // Tag SRAM: byte-lane writes, registered read; read data is scrambled on idle cycles.
  always @(posedge clk) begin
    if (sram_req && sram_write) begin
      for (int w = 0; w < WAYS; w++)
        if (sram_be[w]) mem[sram_addr][w*EW +: EW] <= sram_wdata[w*EW +: EW];
    end
    if (sram_req && !sram_write) sram_rdata <= mem[sram_addr];
    else sram_rdata <= DW'({$urandom, $urandom});
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

  function automatic void model_clear();
    for (int l = 0; l < LINES; l++)
      for (int w = 0; w < WAYS; w++) begin
        mv[l][w] = 1'b0; me[l][w] = 1'b0; mt[l][w] = '0;
      end
  endfunction

  function automatic void model_write(int line, int w, logic [7:0] tag, logic e);
    mv[line][w] = 1'b1; me[line][w] = e; mt[line][w] = tag;
  endfunction

  // {hit, way, error}: first valid way holding the tag wins.
  function automatic logic [5:0] model_lookup(int line, logic [7:0] tag);
    for (int w = 0; w < WAYS; w++)
      if (mv[line][w] && mt[line][w] == tag) return {1'b1, 4'(1 << w), me[line][w]};
    return 6'b0;
  endfunction

  task automatic check_sweep(input string name);
    logic [52:0] got, exp;
    for (int i = 0; i < LINES; i++) begin
      #1;
      got = {sram_req, sram_write, sram_addr, sram_wdata, sram_be, busy, write_gnt, lookup_gnt};
      exp = {1'b1, 1'b1, 4'(i), 40'd0, 4'hF, 1'b1, 2'b00};
      total++;
      if (got !== exp) $display("FAIL %s cycle %0d: got %h want %h", name, i, got, exp);
      else passed++;
      @(negedge clk);
    end
    #1;
    total++;
    if ({busy, write_gnt} !== 2'b01) $display("FAIL %s_end busy/wgnt: got %b want 01", name, {busy, write_gnt});
    else passed++;
  endtask

  task automatic do_write(input int line, input int w, input logic [7:0] tag, input logic e);
    @(negedge clk);
    write_req = 1'b1; write_addr = 4'(line); write_way = 2'(w); write_tag = tag; write_error = e;
    #1;
    total++;
    if ({write_gnt, sram_req, sram_write} !== 3'b111) $display("FAIL do_write gnt: got %b want 111", {write_gnt, sram_req, sram_write});
    else passed++;
    model_write(line, w, tag, e);
    @(negedge clk);
    write_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({busy, sram_req, write_gnt, lookup_gnt, lookup_valid} !== 5'b10000)
      $display("FAIL reset_outputs: got %b want 10000", {busy, sram_req, write_gnt, lookup_gnt, lookup_valid});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    check_sweep("reset_sweep");
    model_clear();
  endtask

  task automatic test_write_lookup();
    logic [5:0] exp;
    @(negedge clk);
    write_req = 1'b1; write_addr = 4'd5; write_way = 2'd2; write_tag = 8'hA5; write_error = 1'b0;
    #1;
    total++;
    if ({write_gnt, sram_req, sram_write, sram_addr, sram_be} !== {3'b111, 4'd5, 4'b0100})
      $display("FAIL write_cmd: got %b want 111_0101_0100", {write_gnt, sram_req, sram_write, sram_addr, sram_be});
    else passed++;
    total++;
    if (sram_wdata !== {4{10'h2A5}}) $display("FAIL write_wdata: got %h want %h", sram_wdata, {4{10'h2A5}});
    else passed++;
    model_write(5, 2, 8'hA5, 1'b0);
    @(negedge clk);
    write_req = 1'b0; lookup_req = 1'b1; lookup_addr = 4'd5; lookup_tag = 8'hA5; ready = 1'b1;
    #1;
    total++;
    if ({lookup_gnt, sram_req, sram_write, sram_addr} !== {3'b110, 4'd5})
      $display("FAIL lookup_cmd: got %b want 110_0101", {lookup_gnt, sram_req, sram_write, sram_addr});
    else passed++;
    exp = model_lookup(5, 8'hA5);
    @(negedge clk);
    lookup_tag = 8'hA6;
    #1;
    total++;
    if ({lookup_valid, hit, way, err, lookup_gnt} !== {1'b1, exp, 1'b1})
      $display("FAIL lookup_hit: got %b want %b", {lookup_valid, hit, way, err, lookup_gnt}, {1'b1, exp, 1'b1});
    else passed++;
    exp = model_lookup(5, 8'hA6);
    @(negedge clk);
    lookup_req = 1'b0;
    #1;
    total++;
    if ({lookup_valid, hit, way, err} !== {1'b1, exp})
      $display("FAIL lookup_miss: got %b want %b", {lookup_valid, hit, way, err}, {1'b1, exp});
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [5:0] exp;
    @(negedge clk);
    lookup_req = 1'b1; lookup_addr = 4'd5; lookup_tag = 8'hA5; ready = 1'b0;
    #1;
    total++;
    if (lookup_gnt !== 1'b1) $display("FAIL bp_gnt: got %b want 1", lookup_gnt);
    else passed++;
    exp = model_lookup(5, 8'hA5);
    @(negedge clk);
    lookup_tag = 8'hA6;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if ({lookup_valid, hit, way, err, lookup_gnt, sram_req} !== {1'b1, exp, 2'b00})
        $display("FAIL bp_hold cycle %0d: got %b want %b", k, {lookup_valid, hit, way, err, lookup_gnt, sram_req}, {1'b1, exp, 2'b00});
      else passed++;
      @(negedge clk);
    end
    ready = 1'b1;
    #1;
    total++;
    if ({lookup_valid, hit, way, err, lookup_gnt, sram_req} !== {1'b1, exp, 2'b11})
      $display("FAIL bp_release: got %b want %b", {lookup_valid, hit, way, err, lookup_gnt, sram_req}, {1'b1, exp, 2'b11});
    else passed++;
    exp = model_lookup(5, 8'hA6);
    @(negedge clk);
    lookup_req = 1'b0;
    #1;
    total++;
    if ({lookup_valid, hit, way, err} !== {1'b1, exp})
      $display("FAIL bp_next: got %b want %b", {lookup_valid, hit, way, err}, {1'b1, exp});
    else passed++;
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    write_req = 1'b1; write_addr = 4'd9; write_way = 2'd0; write_tag = 8'h11; write_error = 1'b0;
    lookup_req = 1'b1; lookup_addr = 4'd9; lookup_tag = 8'h11; ready = 1'b1;
    #1;
    total++;
    if ({write_gnt, lookup_gnt, sram_write} !== 3'b101) $display("FAIL simul_grant: got %b want 101", {write_gnt, lookup_gnt, sram_write});
    else passed++;
    model_write(9, 0, 8'h11, 1'b0);
    @(negedge clk);
    write_req = 1'b0;
    #1;
    total++;
    if (lookup_gnt !== 1'b1) $display("FAIL simul_lookup_gnt: got %b want 1", lookup_gnt);
    else passed++;
    @(negedge clk);
    lookup_req = 1'b0;
    #1;
    total++;
    if ({lookup_valid, hit, way, err} !== {1'b1, model_lookup(9, 8'h11)})
      $display("FAIL simul_result: got %b want %b", {lookup_valid, hit, way, err}, {1'b1, model_lookup(9, 8'h11)});
    else passed++;
  endtask

  task automatic test_duplicate();
    do_write(7, 1, 8'h3C, 1'b1);
    do_write(7, 3, 8'h3C, 1'b0);
    do_write(7, 0, 8'h3D, 1'b0);
    @(negedge clk);
    lookup_req = 1'b1; lookup_addr = 4'd7; lookup_tag = 8'h3C; ready = 1'b1;
    @(negedge clk);
    lookup_req = 1'b0;
    #1;
    total++;
    if ({lookup_valid, hit, way, err} !== {1'b1, model_lookup(7, 8'h3C)})
      $display("FAIL dup_result: got %b want %b", {lookup_valid, hit, way, err}, {1'b1, model_lookup(7, 8'h3C)});
    else passed++;
  endtask

  task automatic test_random();
    logic [5:0] q[$];
    logic exp_lg;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      write_req   = ($urandom_range(0, 9) < 3);
      write_addr  = 4'($urandom_range(0, 3));
      write_way   = 2'($urandom_range(0, 3));
      write_tag   = 8'(8'h50 + $urandom_range(0, 3));
      write_error = 1'($urandom_range(0, 1));
      lookup_req  = ($urandom_range(0, 9) < 6);
      lookup_addr = 4'($urandom_range(0, 3));
      lookup_tag  = 8'(8'h50 + $urandom_range(0, 3));
      ready       = ($urandom_range(0, 9) < 7);
      #1;
      total++;
      if (lookup_valid !== (q.size() != 0)) $display("FAIL rand_valid cycle %0d: got %b want %b", c, lookup_valid, q.size() != 0);
      else passed++;
      if (q.size() != 0) begin
        total++;
        if ({hit, way, err} !== q[0]) $display("FAIL rand_result cycle %0d: got %b want %b", c, {hit, way, err}, q[0]);
        else passed++;
      end
      exp_lg = !write_req && (q.size() == 0 || ready);
      total++;
      if ({write_gnt, lookup_gnt} !== {1'b1, exp_lg}) $display("FAIL rand_grants cycle %0d: got %b want %b", c, {write_gnt, lookup_gnt}, {1'b1, exp_lg});
      else passed++;
      if (q.size() != 0 && ready) void'(q.pop_front());
      if (write_req) model_write(int'(write_addr), int'(write_way), write_tag, write_error);
      else if (lookup_req && exp_lg) q.push_back(model_lookup(int'(lookup_addr), lookup_tag));
    end
    @(negedge clk);
    write_req = 1'b0; lookup_req = 1'b0; ready = 1'b1;
    #1;
    if (q.size() != 0) begin
      total++;
      if ({lookup_valid, hit, way, err} !== {1'b1, q[0]}) $display("FAIL rand_drain: got %b want %b", {lookup_valid, hit, way, err}, {1'b1, q[0]});
      else passed++;
      void'(q.pop_front());
    end
    @(negedge clk);
    #1;
    total++;
    if (lookup_valid !== 1'b0) $display("FAIL rand_idle: got %b want 0", lookup_valid);
    else passed++;
  endtask

  task automatic test_flush();
    logic [5:0] exp;
    do_write(5, 2, 8'hA5, 1'b0);
    @(negedge clk);
    lookup_req = 1'b1; lookup_addr = 4'd5; lookup_tag = 8'hA5; ready = 1'b0;
    #1;
    total++;
    if (lookup_gnt !== 1'b1) $display("FAIL flush_setup_gnt: got %b want 1", lookup_gnt);
    else passed++;
    exp = model_lookup(5, 8'hA5);
    @(negedge clk);
    lookup_req = 1'b0; flush = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if ({busy, lookup_gnt, sram_req, lookup_valid} !== 4'b0001)
        $display("FAIL flush_wait cycle %0d: got %b want 0001", k, {busy, lookup_gnt, sram_req, lookup_valid});
      else passed++;
      @(negedge clk);
    end
    ready = 1'b1;
    #1;
    total++;
    if ({busy, write_gnt, lookup_gnt, sram_req, lookup_valid, hit, way, err} !== {5'b00001, exp})
      $display("FAIL flush_handshake: got %b want %b", {busy, write_gnt, lookup_gnt, sram_req, lookup_valid, hit, way, err}, {5'b00001, exp});
    else passed++;
    @(negedge clk);
    flush = 1'b0;
    check_sweep("flush_sweep");
    model_clear();
    @(negedge clk);
    lookup_req = 1'b1; lookup_addr = 4'd5; lookup_tag = 8'hA5;
    @(negedge clk);
    lookup_req = 1'b0;
    #1;
    total++;
    if ({lookup_valid, hit, way, err} !== {1'b1, model_lookup(5, 8'hA5)})
      $display("FAIL flush_miss: got %b want %b", {lookup_valid, hit, way, err}, {1'b1, model_lookup(5, 8'hA5)});
    else passed++;
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk);
    flush = 1'b1; ready = 1'b1;
    #1;
    total++;
    if ({busy, write_gnt, lookup_gnt} !== 3'b000) $display("FAIL midrst_flush_start: got %b want 000", {busy, write_gnt, lookup_gnt});
    else passed++;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if ({sram_req, sram_addr} !== {1'b1, 4'(i)}) $display("FAIL midrst_sweep line %0d: got %b want %b", i, {sram_req, sram_addr}, {1'b1, 4'(i)});
      else passed++;
      if (i < 9) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, sram_req, write_gnt, lookup_gnt, lookup_valid} !== 5'b10000)
      $display("FAIL midrst_in_reset: got %b want 10000", {busy, sram_req, write_gnt, lookup_gnt, lookup_valid});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    check_sweep("restart_sweep");
    model_clear();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_lookup();
    test_backpressure();
    test_simultaneous();
    test_duplicate();
    test_random();
    test_flush();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/snitch_icache_tag_ctrl.md
# snitch_icache_tag_ctrl

Initiator-side controller for the L0/L1 instruction-cache tag SRAM. Accepts tag lookups and refill tag writes from the cache front-end, drives the single-port tag memory (one entry of `TAG_WIDTH+2` bits per way, all ways in one word, one byte-enable per way), and compares the returned tags to produce hit/way/error. Also owns the invalidation sweep after reset and on flush.

## Interface
- `CFG`, `'0`: `snitch_icache_pkg::config_t`; uses `WAY_COUNT`, `TAG_WIDTH`, `LINE_COUNT`, `COUNT_ALIGN` (= $clog2(LINE_COUNT)).
- Entry format per way: bit `TAG_WIDTH+1` = valid, bit `TAG_WIDTH` = error, `[TAG_WIDTH-1:0]` = tag. Way w occupies word bits `[w*(TAG_WIDTH+2) +: TAG_WIDTH+2]`.

Ports:
- `clk_i`  in  1  clock. Single clock domain.
- `rst_ni`  in  1  reset. Synchronous, active-low.
- `flush_i`  in  1  level request to invalidate all lines.
- `busy_o`  out  1  invalidation sweep in progress.
- `lookup_req_i` / `lookup_gnt_o`  in/out  1  lookup request handshake.
- `lookup_addr_i`  in  COUNT_ALIGN  line index.
- `lookup_tag_i`  in  TAG_WIDTH  tag to compare.
- `lookup_valid_o` / `lookup_ready_i`  out/in  1  response handshake.
- `lookup_hit_o`  out  1  valid entry with matching tag.
- `lookup_way_o`  out  WAY_COUNT  one-hot hit way, 0 on miss.
- `lookup_error_o`  out  1  error bit of the hit way, 0 on miss.
- `write_req_i` / `write_gnt_o`  in/out  1  refill write handshake.
- `write_addr_i`  in  COUNT_ALIGN  line index.
- `write_way_i`  in  $clog2(WAY_COUNT)  target way.
- `write_tag_i`  in  TAG_WIDTH  tag.
- `write_error_i`  in  1  error flag stored with the entry.
- `sram_req_o`, `sram_write_o`  out  1  SRAM request and write enable.
- `sram_addr_o`  out  COUNT_ALIGN  SRAM address.
- `sram_wdata_o`  out  WAY_COUNT*(TAG_WIDTH+2)  write data.
- `sram_be_o`  out  WAY_COUNT  per-way write enable.
- `sram_rdata_i`  in  WAY_COUNT*(TAG_WIDTH+2)  read data, valid exactly one cycle after the read request.

## Operation
- FSM states:
  - INIT: one SRAM write per cycle. addr = sweep counter, wdata = 0, be = all ones. Counter runs 0..LINE_COUNT-1, then goes to IDLE. `busy_o` = 1. Both grants = 0.
  - IDLE: serves writes and lookups.
- Reset: state = INIT, counter = 0, no response pending, hold registers = 0. While `rst_ni` = 0: `sram_req_o`, both grants and `lookup_valid_o` are forced to 0. `busy_o` = 1. Reset during a sweep restarts the sweep at line 0.
- Priority in IDLE: flush > write > lookup.
- Flush: `flush_i` moves IDLE to INIT only when no response is pending, or when the pending response handshakes in that same cycle. Neither grant is given that cycle.
- Write:
  - `write_gnt_o` = IDLE && !flush-start.
  - On grant: SRAM write to `write_addr_i`. Every lane of wdata = {1, `write_error_i`, `write_tag_i`}. be = onehot(`write_way_i`).
- Lookup:
  - `lookup_gnt_o` = IDLE && !`write_req_i` && !flush-start && (no pending response, or pending response handshaking this cycle).
  - On grant: SRAM read.
  - Next cycle: compare every way, where match = valid && tag == `lookup_tag` registered at grant.
  - Several ways match: report the lowest index only.
- Response hold: if the response is not accepted in its first cycle, the controller captures hit/way/error into registers. Outputs come from those registers until `lookup_ready_i`. The SRAM is not re-read.
- A write to the line of a pending response does not alter that response.

## Timing
- Lookup granted at cycle t: `lookup_valid_o` at t+1, results combinational from `sram_rdata_i`.
- Throughput is one lookup per cycle with `lookup_ready_i` held high.
- Write granted at t: SRAM write at t. A lookup granted at t+1 to the same line observes the new entry.
- Sweep takes exactly LINE_COUNT cycles. First SRAM write is in the first cycle after reset deasserts.
- All outputs are stable while `lookup_valid_o` && !`lookup_ready_i`.

## Test plan
Configuration: WAY_COUNT=4, TAG_WIDTH=8, LINE_COUNT=16.

1. **Reset sweep.** Deassert reset. Expect 16 consecutive SRAM writes, addr 0..15, wdata 0, be 4'b1111. `busy_o` = 1 for 16 cycles with grants low, then 0.
2. **Write then lookup.** Write line 5, way 2, tag 0xA5, err 0. Expect be 4'b0100 and lane 2 = 10'h2A5. Lookup line 5 tag 0xA5 next cycle: hit=1, way=4'b0100, error=0 at t+1. Lookup tag 0xA6: hit=0, way=0.
3. **Backpressure.** Hit response with `lookup_ready_i` low for 3 cycles. Expect valid/hit/way stable, `lookup_gnt_o`=0, no SRAM request. Raise ready: handshake, and a new lookup is granted the same cycle.
4. **Simultaneous requests.** Write and lookup requested in the same cycle. Expect write granted, lookup granted next cycle and seeing the written tag.
5. **Duplicate match and error.** Ways 1 and 3 hold tag 0x3C on line 7 (way 1 err=1). Lookup 0x3C: way=4'b0010, error=1.
6. **Flush and reset mid-sweep.**
   - Raise `flush_i` with a response pending and ready low. Sweep starts only after the handshake, lasts 16 cycles. A lookup of line 5 tag 0xA5 afterwards misses.
   - Assert reset at sweep line 9. Sweep restarts at addr 0.
